// File: rtl/serdes_frame_tx.sv
// Two-lane serial frame transmitter: START pulse, 8 data bits MSB first, DONE.
// Define SERDES_TX_PARITY_EN to append an even-parity bit per lane.
module serdes_frame_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] a_data,
    input  logic [7:0] b_data,
    output logic       in_ready,
    output logic       start_o,
    output logic       a_bit,
    output logic       b_bit,
    output logic       busy,
    output logic       done,
    output logic [7:0] frame_cnt
);

`ifdef SERDES_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, SHIFT, PAR, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, SHIFT, DONE} state_t;
`endif

    state_t     r_state;
    state_t     w_next;
    logic       r_hold_full;
    logic [7:0] r_hold_a;
    logic [7:0] r_hold_b;
    logic [7:0] r_sh_a;
    logic [7:0] r_sh_b;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_frame_cnt;
    logic       w_accept;
    logic       w_load;

    assign w_accept = in_valid && !r_hold_full;
    assign w_load   = r_hold_full && (r_state == IDLE || r_state == DONE);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (r_hold_full) w_next = START;
            START: w_next = SHIFT;
`ifdef SERDES_TX_PARITY_EN
            SHIFT: if (r_bit_cnt == 3'd7) w_next = PAR;
            PAR:   w_next = DONE;
`else
            SHIFT: if (r_bit_cnt == 3'd7) w_next = DONE;
`endif
            DONE:  w_next = r_hold_full ? START : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Accept and transfer are mutually exclusive: one needs empty, one full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_a    <= 8'd0;
            r_hold_b    <= 8'd0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_a    <= a_data;
            r_hold_b    <= b_data;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_a    <= 8'd0;
            r_sh_b    <= 8'd0;
            r_bit_cnt <= 3'd0;
        end else if (w_load) begin
            r_sh_a    <= r_hold_a;
            r_sh_b    <= r_hold_b;
            r_bit_cnt <= 3'd0;
        end else if (r_state == SHIFT) begin
            r_sh_a    <= {r_sh_a[6:0], 1'b0};
            r_sh_b    <= {r_sh_b[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

`ifdef SERDES_TX_PARITY_EN
    logic r_par_a;
    logic r_par_b;

    // Parity is latched at load since the shifters are drained by PAR time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_a <= 1'b0;
            r_par_b <= 1'b0;
        end else if (w_load) begin
            r_par_a <= ^r_hold_a;
            r_par_b <= ^r_hold_b;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 8'd0;
        end else if (r_state == DONE) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    always_comb begin
        a_bit = 1'b0;
        b_bit = 1'b0;
        if (r_state == SHIFT) begin
            a_bit = r_sh_a[7];
            b_bit = r_sh_b[7];
        end
`ifdef SERDES_TX_PARITY_EN
        if (r_state == PAR) begin
            a_bit = r_par_a;
            b_bit = r_par_b;
        end
`endif
    end

    assign in_ready  = !r_hold_full;
    assign start_o   = (r_state == START);
    assign done      = (r_state == DONE);
    assign busy      = (r_state != IDLE) || r_hold_full;
    assign frame_cnt = r_frame_cnt;

endmodule
